regfile_debug_access: RTL and testbench
=======================================

// Module: regfile_debug_access
// PURPOSE
//  Debug-side initiator for the 32x32 register file (two read ports A1/A2, one write port A3/WD3/WE3).
//  Accepts single read/write commands from the debug host over a valid/ready request/response pair.
//  Halts the core, takes over read port 1 and the write port for one cycle, returns the result, then releases the core.
//  Sits between the debug transport and the register-file port muxes in the core top level.
// PARAMETERS
//  HALT_TIMEOUT  255  max cycles to wait for halt_ack before aborting with error (1..255)
// PORTS
//  clk            in   1   core clock; all state changes on rising edge
//  rst            in   1   reset, asynchronous, active-low (0 = reset)
//  dbg_req_valid  in   1   host command valid
//  dbg_req_ready  out  1   block can accept a command (high only in IDLE)
//  dbg_req_write  in   1   1 = write, 0 = read
//  dbg_req_addr   in   5   register index x0..x31
//  dbg_req_wdata  in   32  write data
//  dbg_rsp_valid  out  1   response valid
//  dbg_rsp_ready  in   1   host accepts response
//  dbg_rsp_rdata  out  32  read data (0 for writes and errors)
//  dbg_rsp_err    out  1   1 = halt timeout, access not performed
//  halt_req       out  1   request core stall
//  halt_ack       in   1   core is stalled; regfile ports may be taken over
//  rf_sel         out  1   1 = top-level muxes route rf_a1/rf_a3/rf_wd3/rf_we3 to the regfile
//  rf_a1          out  5   regfile read address
//  rf_rd1         in   32  regfile read data (combinational from rf_a1)
//  rf_a3          out  5   regfile write address
//  rf_wd3         out  32  regfile write data
//  rf_we3         out  1   regfile write enable
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; every output 0 except dbg_req_ready=1; command/timeout regs cleared.
//  Reset mid-operation: same; halt_req drops immediately, rf_we3 deasserts without completing the write; no response issued.
//  FSM: IDLE -> HALT -> ACCESS -> RESP -> RELEASE -> IDLE; HALT -> RESP on timeout.
//  IDLE: dbg_req_ready=1. Edge with valid&ready latches write/addr/wdata, clears timer, goes HALT.
//  HALT: halt_req=1. Edge with halt_ack=1 -> ACCESS. Otherwise timer++; at timer==HALT_TIMEOUT-1 with ack still 0
//    -> RESP with err=1, rdata=0.
//  ACCESS (exactly 1 cycle): halt_req=1, rf_sel=1, rf_a1=rf_a3=addr, rf_wd3=wdata, rf_we3=write&(addr!=0).
//    Read: rdata <= (addr==0) ? 0 : rf_rd1 at end of cycle. Write: rdata <= 0. err <= 0. -> RESP.
//  x0: writes are suppressed (rf_we3 stays 0), response err=0; reads return 0 regardless of regfile content.
//  RESP: halt_req held (err=0 case) or held (err=1 case; released next state); dbg_rsp_valid=1, rdata/err stable
//    until edge with dbg_rsp_ready=1 -> RELEASE.
//  RELEASE: halt_req=0, rf_sel=0; waits for halt_ack=0, then IDLE (if ack already 0, next edge -> IDLE).
//  rf_sel/rf_we3 are high only in ACCESS; rf_a*/rf_wd3 are 0 outside ACCESS.
//  Latency with halt_ack already high: request edge T0; rsp_valid high from T2 (2 cycles after acceptance).
//  dbg_req_valid while not IDLE is ignored (ready=0); command fields sampled only at acceptance edge.
//  halt_ack falling during ACCESS is not checked; core must hold stall while halt_req=1.
// TESTING
//  Read x5 (regfile x5=0xDEADBEEF), halt_ack tied 1 -> rsp_valid at 2 cycles after accept, rdata=0xDEADBEEF, err=0.
//  Write x7=0x12345678 -> one-cycle rf_we3=1, rf_a3=7, rf_wd3=0x12345678, rf_sel=1; follow-up read x7 returns it.
//  Write x0=0xFFFFFFFF then read x0 -> rf_we3 never asserts; read rdata=0, err=0 on both.
//  HALT_TIMEOUT=4, halt_ack held 0 -> rsp_valid after 4 HALT cycles, err=1, rdata=0, rf_we3 never 1, halt_req drops.
//  dbg_rsp_ready held 0 for 10 cycles -> rsp_valid/rdata stable, halt_req stays 1, dbg_req_ready stays 0.
//  rst low during ACCESS of a write -> all outputs 0 (ready=1) immediately, no response; next command completes normally.

Source files
------------

// File: rtl/regfile_debug_access.sv
// Debug-side initiator for the 32x32 register file.
// Takes one read or write command from the debug host. It halts the core,
// drives read port 1 and the write port for a single cycle, returns the
// response, and then releases the core. Every output is registered.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a host command (dbg_req_ready=1)
// HALT    | halt_req raised, waiting for halt_ack or timeout
// ACCESS  | one cycle owning the regfile ports (rf_sel=1)
// RESP    | response held valid until the host accepts it
// RELEASE | halt_req dropped, waiting for the core to drop halt_ack
module regfile_debug_access #(
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbg_req_valid,
   output logic        dbg_req_ready,
   input  logic        dbg_req_write,
   input  logic [4:0]  dbg_req_addr,
   input  logic [31:0] dbg_req_wdata,
   output logic        dbg_rsp_valid,
   input  logic        dbg_rsp_ready,
   output logic [31:0] dbg_rsp_rdata,
   output logic        dbg_rsp_err,
   output logic        halt_req,
   input  logic        halt_ack,
   output logic        rf_sel,
   output logic [4:0]  rf_a1,
   input  logic [31:0] rf_rd1,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wd3,
   output logic        rf_we3
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HALT    = 3'd1,
      S_ACCESS  = 3'd2,
      S_RESP    = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   // The timer counts the HALT cycles that have already gone by without an
   // ack. On the cycle where it reaches its last value, the access is abandoned.
   localparam logic [7:0] TIMER_LAST = 8'(HALT_TIMEOUT - 1);

   state_t      state;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [7:0]  timer;

   // Sequencer: the state, the latched command and every output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cmd_write     <= 1'b0;
         cmd_addr      <= 5'd0;
         cmd_wdata     <= 32'd0;
         timer         <= 8'd0;
         dbg_req_ready <= 1'b1;
         dbg_rsp_valid <= 1'b0;
         dbg_rsp_rdata <= 32'd0;
         dbg_rsp_err   <= 1'b0;
         halt_req      <= 1'b0;
         rf_sel        <= 1'b0;
         rf_a1         <= 5'd0;
         rf_a3         <= 5'd0;
         rf_wd3        <= 32'd0;
         rf_we3        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (dbg_req_valid) begin
                  cmd_write     <= dbg_req_write;
                  cmd_addr      <= dbg_req_addr;
                  cmd_wdata     <= dbg_req_wdata;
                  timer         <= 8'd0;
                  dbg_req_ready <= 1'b0;
                  halt_req      <= 1'b1;
                  state         <= S_HALT;
               end
            end
            S_HALT: begin
               if (halt_ack) begin
                  rf_sel <= 1'b1;
                  rf_a1  <= cmd_addr;
                  rf_a3  <= cmd_addr;
                  rf_wd3 <= cmd_wdata;
                  // x0 is hardwired to zero, so a write to it never reaches the regfile.
                  rf_we3 <= cmd_write & (cmd_addr != 5'd0);
                  state  <= S_ACCESS;
               end else if (timer == TIMER_LAST) begin
                  dbg_rsp_valid <= 1'b1;
                  dbg_rsp_rdata <= 32'd0;
                  dbg_rsp_err   <= 1'b1;
                  state         <= S_RESP;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_ACCESS: begin
               rf_sel        <= 1'b0;
               rf_a1         <= 5'd0;
               rf_a3         <= 5'd0;
               rf_wd3        <= 32'd0;
               rf_we3        <= 1'b0;
               dbg_rsp_valid <= 1'b1;
               dbg_rsp_err   <= 1'b0;
               dbg_rsp_rdata <= (!cmd_write && (cmd_addr != 5'd0)) ? rf_rd1 : 32'd0;
               state         <= S_RESP;
            end
            S_RESP: begin
               if (dbg_rsp_ready) begin
                  dbg_rsp_valid <= 1'b0;
                  dbg_rsp_rdata <= 32'd0;
                  dbg_rsp_err   <= 1'b0;
                  halt_req      <= 1'b0;
                  state         <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!halt_ack) begin
                  dbg_req_ready <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: begin
               dbg_req_ready <= 1'b1;
               dbg_rsp_valid <= 1'b0;
               halt_req      <= 1'b0;
               rf_sel        <= 1'b0;
               rf_we3        <= 1'b0;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_debug_access.sv
// Bench for regfile_debug_access. It provides a small regfile model and a
// core model whose halt_ack either follows halt_req or stays low. Expected
// responses are pushed to a scoreboard when a command is issued. They are
// popped and compared when the response is accepted.
module tb_regfile_debug_access;

   localparam int unsigned HT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        dbg_req_valid = 1'b0;
   logic        dbg_req_ready;
   logic        dbg_req_write = 1'b0;
   logic [4:0]  dbg_req_addr = 5'd0;
   logic [31:0] dbg_req_wdata = 32'd0;
   logic        dbg_rsp_valid;
   logic        dbg_rsp_ready = 1'b0;
   logic [31:0] dbg_rsp_rdata;
   logic        dbg_rsp_err;
   logic        halt_req;
   logic        halt_ack;
   logic        rf_sel;
   logic [4:0]  rf_a1;
   logic [31:0] rf_rd1;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd3;
   logic        rf_we3;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   rsp_t        sb[$];
   logic [31:0] mem [32];
   logic [31:0] ref_mem [32];
   logic        preload = 1'b1;
   int          ack_mode = 1;
   int          we_cnt = 0;
   int          sel_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_debug_access #(.HALT_TIMEOUT(HT)) dut (
      .clk(clk), .rst(rst),
      .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
      .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
      .dbg_req_wdata(dbg_req_wdata),
      .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
      .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_rsp_err(dbg_rsp_err),
      .halt_req(halt_req), .halt_ack(halt_ack),
      .rf_sel(rf_sel), .rf_a1(rf_a1), .rf_rd1(rf_rd1),
      .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3)
   );

   // Core model: it stalls as soon as it is asked, or it never stalls.
   assign halt_ack = (ack_mode == 1) ? halt_req : 1'b0;
   assign rf_rd1   = mem[rf_a1];

   // Regfile model. x0 holds junk on purpose: a debug read of x0 must still return 0.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
         mem[0] <= 32'hCAFEF00D;
         mem[5] <= 32'hDEADBEEF;
      end else if (rf_sel && rf_we3) begin
         mem[rf_a3] <= rf_wd3;
      end
   end

   // Count the cycles in which the write enable and the port select are high.
   always @(posedge clk) begin
      if (rf_we3) we_cnt <= we_cnt + 1;
      if (rf_sel) sel_cnt <= sel_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, 32'({dbg_req_ready, dbg_rsp_valid, dbg_rsp_err, halt_req, rf_sel, rf_we3}), 32'h20);
      check({tag, "_addr"}, 32'({rf_a1, rf_a3}), 32'd0);
      check({tag, "_wd3"}, rf_wd3, 32'd0);
      check({tag, "_rdata"}, dbg_rsp_rdata, 32'd0);
   endtask

   task automatic do_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                         input int am, input int stall);
      rsp_t er;
      rsp_t got;
      logic e;
      logic exp_we;
      int   lat;
      int   n;
      int   we0;
      int   sel0;
      e        = (am == 0);
      exp_we   = !e && wr && (addr != 5'd0);
      er.err   = e;
      er.rdata = (e || wr || addr == 5'd0) ? 32'd0 : ref_mem[addr];
      if (exp_we) ref_mem[addr] = wd;
      sb.push_back(er);
      ack_mode = am;
      we0  = we_cnt;
      sel0 = sel_cnt;

      check("req_ready_idle", 32'(dbg_req_ready), 32'd1);
      dbg_req_valid = 1'b1;
      dbg_req_write = wr;
      dbg_req_addr  = addr;
      dbg_req_wdata = wd;
      @(posedge clk); #1;
      dbg_req_valid = 1'b0;
      dbg_req_write = ~wr;
      dbg_req_addr  = ~addr;
      dbg_req_wdata = ~wd;
      check("halt_req_halt", 32'(halt_req), 32'd1);
      check("req_ready_busy", 32'(dbg_req_ready), 32'd0);

      lat = 0;
      while (!dbg_rsp_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         if (!dbg_rsp_valid) begin
            check("halt_req_hold", 32'(halt_req), 32'd1);
            if (e) check("we3_timeout", 32'(rf_we3), 32'd0);
         end
         if (lat == 1 && !e) begin
            check("acc_sel", 32'(rf_sel), 32'd1);
            check("acc_a1", 32'(rf_a1), 32'(addr));
            check("acc_a3", 32'(rf_a3), 32'(addr));
            check("acc_wd3", rf_wd3, wd);
            check("acc_we3", 32'(rf_we3), 32'(exp_we));
         end
      end
      check("rsp_latency", 32'(lat), e ? 32'(HT) : 32'd2);
      check("rsp_halt_req", 32'(halt_req), 32'd1);
      check("rsp_ports_idle", 32'({rf_sel, rf_we3, rf_a1, rf_a3}), 32'd0);
      check("rsp_wd3_idle", rf_wd3, 32'd0);
      check("we3_cycles", 32'(we_cnt - we0), 32'(exp_we));
      check("sel_cycles", 32'(sel_cnt - sel0), 32'(!e));

      for (int i = 0; i < stall; i++) begin
         if (i == 0) begin
            dbg_req_valid = 1'b1;
            dbg_req_write = 1'b1;
            dbg_req_addr  = 5'd3;
            dbg_req_wdata = 32'h0BAD0BAD;
         end
         @(posedge clk); #1;
         check("stall_valid", 32'(dbg_rsp_valid), 32'd1);
         check("stall_rdata", dbg_rsp_rdata, er.rdata);
         check("stall_halt_req", 32'(halt_req), 32'd1);
         check("stall_req_ready", 32'(dbg_req_ready), 32'd0);
      end

      dbg_rsp_ready = 1'b1;
      check("sb_size", 32'(sb.size()), 32'd1);
      got = sb.pop_front();
      check("rsp_rdata", dbg_rsp_rdata, got.rdata);
      check("rsp_err", 32'(dbg_rsp_err), 32'(got.err));
      @(posedge clk); #1;
      dbg_rsp_ready = 1'b0;
      dbg_req_valid = 1'b0;
      check("release_valid", 32'(dbg_rsp_valid), 32'd0);
      check("release_halt_req", 32'(halt_req), 32'd0);
      n = 0;
      while (!dbg_req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("back_to_idle", 32'(dbg_req_ready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
      ref_mem[5] = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      preload = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_quiet("idle_after_reset");

      do_cmd(1'b0, 5'd5,  32'h0,        1, 0);
      do_cmd(1'b1, 5'd7,  32'h12345678, 1, 0);
      do_cmd(1'b0, 5'd7,  32'h0,        1, 0);
      do_cmd(1'b1, 5'd0,  32'hFFFFFFFF, 1, 0);
      do_cmd(1'b0, 5'd0,  32'h0,        1, 0);
      do_cmd(1'b0, 5'd5,  32'h0,        0, 0);
      do_cmd(1'b1, 5'd3,  32'h11112222, 0, 0);
      do_cmd(1'b0, 5'd3,  32'h0,        1, 0);
      do_cmd(1'b0, 5'd7,  32'h0,        1, 10);

      // Apply reset in the middle of the ACCESS cycle of a write to x9.
      ack_mode      = 1;
      dbg_req_valid = 1'b1;
      dbg_req_write = 1'b1;
      dbg_req_addr  = 5'd9;
      dbg_req_wdata = 32'hA5A5A5A5;
      @(posedge clk); #1;
      dbg_req_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_pre_we3", 32'(rf_we3), 32'd1);
      rst = 1'b0;
      #1;
      check_quiet("rst_mid_access");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_no_rsp", 32'(dbg_rsp_valid), 32'd0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      check_quiet("rst_release");

      do_cmd(1'b0, 5'd9,  32'h0,        1, 0);
      do_cmd(1'b1, 5'd31, 32'hFACE0031, 1, 2);
      do_cmd(1'b0, 5'd31, 32'h0,        1, 0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
